// File: rtl/aes_dec_core.sv
// Iterative AES-128 inverse cipher, one round per clock. Round keys are rolled
// forward to k10 during KEXP, then rolled back one step per round.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[a];
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y = ISBOX[a];
endmodule

module aes_dec_core (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic         dec_cs,
    input  logic [127:0] ciphertext_i,
    input  logic [127:0] key_i,
    output logic [127:0] plaintext_o,
    output logic         dec_done,
    output logic         busy_o
);
    // state | meaning
    // IDLE  | waiting for dec_cs
    // KEXP  | forward key expansion k0 -> k10
    // ARK   | initial AddRoundKey with k10
    // ROUND | inverse rounds 10..1, key rolled back each cycle
    // DONE  | result held, restart allowed
    typedef enum logic [2:0] {IDLE, KEXP, ARK, ROUND, DONE} state_t;

    state_t       state;
    logic [127:0] st_q;
    logic [127:0] key_q;
    logic [3:0]   rnd_q;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [127:0] isr, sb, t, imc;

    // Byte b = row + 4*col; row r rotates right by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign isr[127-8*(r+4*c) -: 8] = st_q[127-8*(r+4*((c-r+4)%4)) -: 8];
        end
    end

    for (genvar b = 0; b < 16; b++) begin : g_isb
        aes_inv_sbox u_isb (.a(isr[127-8*b -: 8]), .y(sb[127-8*b -: 8]));
    end

    assign t = sb ^ key_q;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    end

    logic [31:0] w0, w1, w2, w3, ks_word, ks_sub;
    logic [3:0]  rc_idx;
    logic [31:0] rc_word;
    logic [127:0] key_fwd, key_inv;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Forward step feeds SubWord from w3, the inverse step from the recovered w3'.
    assign ks_word = (state == KEXP) ? w3 : (w3 ^ w2);
    assign rc_idx  = (state == ROUND) ? rnd_q - 4'd1 : rnd_q;
    assign rc_word = {rcon(rc_idx), 24'h0};

    for (genvar i = 0; i < 4; i++) begin : g_ksb
        aes_sbox u_sb (.a(ks_word[23-8*i+((i == 3) ? 32 : 0) -: 8]), .y(ks_sub[31-8*i -: 8]));
    end

    logic [31:0] f0;
    assign f0      = w0 ^ ks_sub ^ rc_word;
    assign key_fwd = {f0, w1 ^ f0, w2 ^ w1 ^ f0, w3 ^ w2 ^ w1 ^ f0};
    assign key_inv = {w0 ^ ks_sub ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            st_q        <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            plaintext_o <= '0;
            dec_done    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (dec_cs) begin
                        st_q     <= ciphertext_i;
                        key_q    <= key_i;
                        rnd_q    <= 4'd1;
                        dec_done <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= KEXP;
                    end
                end
                KEXP: begin
                    key_q <= key_fwd;
                    if (rnd_q == 4'd10) state <= ARK;
                    else                rnd_q <= rnd_q + 4'd1;
                end
                ARK: begin
                    st_q  <= st_q ^ key_q;
                    key_q <= key_inv;
                    state <= ROUND;
                end
                ROUND: begin
                    key_q <= key_inv;
                    rnd_q <= rnd_q - 4'd1;
                    if (rnd_q == 4'd1) begin
                        st_q        <= t;
                        plaintext_o <= t;
                        dec_done    <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= DONE;
                    end else begin
                        st_q <= imc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_dec_core.sv
// Directed + random bench for aes_dec_core against a table-free AES-128 decrypt model.

module tb_aes_dec_core;
    logic         wb_clk_i = 1'b0;
    logic         wb_rst_ni = 1'b0;
    logic         dec_cs = 1'b0;
    logic [127:0] ciphertext_i = '0;
    logic [127:0] key_i = '0;
    logic [127:0] plaintext_o;
    logic         dec_done;
    logic         busy_o;

    int total = 0;
    int bad = 0;

    aes_dec_core dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .dec_cs      (dec_cs),
        .ciphertext_i(ciphertext_i),
        .key_i       (key_i),
        .plaintext_o (plaintext_o),
        .dec_done    (dec_done),
        .busy_o      (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    logic [7:0] sb_tab [256];
    logic [7:0] isb_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb_tab[x] = s;
            isb_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_rkey(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [127:0] key);
        logic [7:0]   s [4][4];
        logic [7:0]   u [4][4];
        logic [7:0]   base [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] rk, res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = ct[127-8*(r+4*c) -: 8];
        for (int rnd = 10; rnd >= 0; rnd--) begin
            if (rnd < 10) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) u[r][(c+r)%4] = s[r][c];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) s[r][c] = isb_tab[u[r][c]];
            end
            rk = ref_rkey(key, rnd);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ rk[127-8*(r+4*c) -: 8];
            if (rnd > 0 && rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int i = 0; i < 4; i++) begin
                        u[i][c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            u[i][c] = u[i][c] ^ gmul(base[(j-i+4)%4], s[j][c]);
                    end
                s = u;
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) res[127-8*(r+4*c) -: 8] = s[r][c];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts one block, optionally pulses dec_cs mid-operation, checks k10, latency, busy and result.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] exp_pt, input logic [127:0] exp_k10,
                             input string tag, input int pulse_at);
        int lat = -1;
        int busy_cnt;
        ciphertext_i = ct;
        key_i        = key;
        dec_cs       = 1'b1;
        tick();
        dec_cs       = 1'b0;
        ciphertext_i = rnd128();
        key_i        = rnd128();
        chk({tag, ".done_cleared"}, dec_done, 1'b0);
        busy_cnt = busy_o ? 1 : 0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            if (i == pulse_at) begin
                dec_cs       = 1'b1;
                ciphertext_i = rnd128();
            end
            tick();
            dec_cs = 1'b0;
            if (i == 10) chk({tag, ".k10"}, dut.key_q, exp_k10);
            if (busy_o) busy_cnt++;
            if (dec_done) lat = i;
        end
        chk({tag, ".latency"}, 128'(lat), 128'd21);
        chk({tag, ".plaintext"}, plaintext_o, exp_pt);
        chk({tag, ".busy_cycles"}, 128'(busy_cnt), 128'd21);
        chk({tag, ".busy_low_at_done"}, busy_o, 1'b0);
    endtask

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        logic [127:0] rk, rc;
        int low;
        build_tables();

        wb_rst_ni = 1'b0;
        repeat (3) tick();
        chk("reset.plaintext", plaintext_o, '0);
        chk("reset.done", dec_done, 1'b0);
        chk("reset.busy", busy_o, 1'b0);
        wb_rst_ni = 1'b1;
        tick();

        run_block(C1, K1, P1, ref_rkey(K1, 10), "fips_c1", 0);
        run_block(C2, K2, P2, K2_10, "fips_b", 0);
        run_block(CZ, '0, '0, ref_rkey('0, 10), "zero_key", 0);
        run_block(CZ, '0, '0, ref_rkey('0, 10), "ignored_start", 15);

        // dec_cs held high: results every 22 cycles, alternating vectors
        ciphertext_i = C1;
        key_i        = K1;
        dec_cs       = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            low = 0;
            for (int i = 0; i < 40 && !dec_done; i++) begin
                low++;
                tick();
            end
            chk("b2b.low_cycles", 128'(low), 128'd21);
            chk("b2b.plaintext", plaintext_o, (k % 2 == 0) ? P1 : P2);
            if (k == 3) dec_cs = 1'b0;
            ciphertext_i = (k % 2 == 0) ? C2 : C1;
            key_i        = (k % 2 == 0) ? K2 : K1;
            tick();
        end
        chk("b2b.hold_done", dec_done, 1'b1);
        chk("b2b.hold_plaintext", plaintext_o, P2);

        // mid-operation reset at E0+15
        ciphertext_i = C1;
        key_i        = K1;
        dec_cs       = 1'b1;
        tick();
        dec_cs = 1'b0;
        repeat (14) tick();
        wb_rst_ni = 1'b0;
        tick();
        wb_rst_ni = 1'b1;
        chk("abort.done", dec_done, 1'b0);
        chk("abort.plaintext", plaintext_o, '0);
        chk("abort.busy", busy_o, 1'b0);
        repeat (25) tick();
        chk("abort.no_output", dec_done, 1'b0);
        chk("abort.stays_idle", busy_o, 1'b0);
        run_block(C2, K2, P2, K2_10, "after_abort", 0);

        for (int n = 0; n < 6; n++) begin
            rk = rnd128();
            rc = rnd128();
            run_block(rc, rk, ref_dec(rc, rk), ref_rkey(rk, 10), "random", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
